round_mult_seq: RTL and testbench
=================================

ROUND_MULT_SEQ -- requirements
Module: round_mult_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each unsigned operand.
REQ-002 SHALL have parameter FRAC_BITS, default 3, number of product bits discarded with rounding; legal range 0..2*DATA_WIDTH-1.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, width of the saturated result.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port din_a, input, DATA_WIDTH, unsigned multiplicand.
REQ-007 SHALL have port din_b, input, DATA_WIDTH, unsigned multiplier.
REQ-008 SHALL have port din_valid, input, 1, operands valid.
REQ-009 SHALL have port din_ready, output, 1, block can accept operands.
REQ-010 SHALL have port dout, output, OUT_WIDTH, rounded and saturated result.
REQ-011 SHALL have port dout_sat, output, 1, result was clamped.
REQ-012 SHALL have port dout_valid, output, 1, dout and dout_sat valid.
REQ-013 SHALL have port dout_ready, input, 1, consumer accepts the result.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, ROUND, DONE.
REQ-015 SHALL drive din_ready=1 only in IDLE; dout_valid=1 only in DONE.
REQ-016 SHALL accept operands on the edge where din_valid and din_ready are both 1: latch din_a and din_b, clear the 2*DATA_WIDTH-bit accumulator, clear the bit counter, go to BUSY.
REQ-017 SHALL ignore din_a, din_b and din_valid in every state other than IDLE.
REQ-018 SHALL in BUSY process one multiplier bit per cycle, LSB first, shift-and-add, for exactly DATA_WIDTH cycles, then go to ROUND.
REQ-019 SHALL in ROUND, for one cycle, compute P + 2^(FRAC_BITS-1) (no addend when FRAC_BITS=0), where P is the full unsigned product, at width 2*DATA_WIDTH+1 with no carry loss, then shift right by FRAC_BITS (round half up).
REQ-020 SHALL saturate: if the rounded value exceeds 2^OUT_WIDTH-1, dout is all ones and dout_sat=1; otherwise dout is the rounded value and dout_sat=0.
REQ-021 SHALL register dout and dout_sat on the ROUND to DONE edge; fixed latency: dout_valid rises DATA_WIDTH+1 cycles after the acceptance edge.
REQ-022 SHALL hold dout, dout_sat and dout_valid stable in DONE while dout_ready=0.
REQ-023 SHALL return to IDLE on the edge where dout_valid and dout_ready are both 1; din_ready rises the following cycle; no same-cycle accept-and-deliver.
REQ-024 SHALL give a zero operand a result of 0 with dout_sat=0.

Reset
REQ-025 SHALL on reset=1 at a clock edge enter IDLE and clear dout, dout_sat, dout_valid, accumulator and counter to 0, with din_ready=1 after the edge.
REQ-026 SHALL have reset take priority over all handshakes; reset in BUSY, ROUND or DONE aborts the operation and discards the result, with no dout_valid pulse for it.

Verification (defaults DATA_WIDTH=8, FRAC_BITS=3, OUT_WIDTH=8)
REQ-027 SHALL cover: a=10, b=5 (P=50, 6.25) -> dout=6, dout_sat=0, dout_valid exactly 9 cycles after acceptance.
REQ-028 SHALL cover the half-way case: a=12, b=5 (P=60, 7.5) -> dout=8; and a=4, b=1 (0.5) -> dout=1.
REQ-029 SHALL cover saturation: a=255, b=255 (P=65025) -> dout=255, dout_sat=1; and a=45, b=45 (P=2025, 253.1) -> dout=253, dout_sat=0.
REQ-030 SHALL cover backpressure: dout_ready=0 for 5 cycles after dout_valid -> dout constant, din_ready=0, din_valid pulses ignored; then dout_ready=1 -> IDLE, din_ready=1 the next cycle.
REQ-031 SHALL cover reset mid-BUSY: reset in cycle 4 of BUSY -> IDLE next cycle, all outputs 0, no result; a new operation a=3, b=3 -> dout=1.
REQ-032 SHALL cover zero operands: a=0, b=200 -> dout=0, dout_sat=0, same latency.

Source files
------------

// File: rtl/round_mult_seq.sv
// Sequential unsigned shift-and-add multiplier. The product is rounded half up,
// FRAC_BITS fraction bits are dropped, and the result saturates to OUT_WIDTH bits.
module round_mult_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 3,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [OUT_WIDTH-1:0]  dout,
  output logic                  dout_sat,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int RW    = PW + 1;
  localparam int EW    = (OUT_WIDTH > RW) ? OUT_WIDTH : RW;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // 2^(FRAC_BITS-1), which collapses to zero when FRAC_BITS is 0
  localparam logic [RW-1:0] HALF = ({{(RW-1){1'b0}}, 1'b1} << FRAC_BITS) >> 1;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 sat_q, sat_d;

  logic [RW-1:0]        rnd_sum;
  logic [EW-1:0]        rnd_ext;
  logic [EW-1:0]        max_ext;

  always_comb begin
    rnd_sum = {1'b0, acc_q} + HALF;
    rnd_ext = '0;
    rnd_ext[RW-1:0] = rnd_sum >> FRAC_BITS;
    max_ext = '0;
    max_ext[OUT_WIDTH-1:0] = '1;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          a_d     = {{DATA_WIDTH{1'b0}}, din_a};
          b_d     = din_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Multiplicand shifts up while the multiplier drains LSB first
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = ROUND;
      end
      ROUND: begin
        if (rnd_ext > max_ext) begin
          dout_d = '1;
          sat_d  = 1'b1;
        end else begin
          dout_d = rnd_ext[OUT_WIDTH-1:0];
          sat_d  = 1'b0;
        end
        state_d = DONE;
      end
      default: begin
        if (dout_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
    end
  end

  assign din_ready  = (state_q == IDLE);
  assign dout_valid = (state_q == DONE);
  assign dout       = dout_q;
  assign dout_sat   = sat_q;

endmodule

// File: tb/tb_round_mult_seq.sv
// Scoreboard bench for round_mult_seq: the driver queues expected results at
// acceptance, a monitor pops and compares whenever a result is handed over.
module tb_round_mult_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din_a, din_b;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_sat;
  logic       dout_valid;
  logic       dout_ready;

  typedef struct { logic [7:0] d; logic s; } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;

  round_mult_seq #(.DATA_WIDTH(8), .FRAC_BITS(3), .OUT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .din_a(din_a), .din_b(din_b), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_sat(dout_sat), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Monitor: a handshake is pending whenever valid and ready are both high
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", int'(dout), int'(e.d));
          chk("dout_sat", int'(dout_sat), int'(e.s));
        end
      end
    end
  end

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!din_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("din_ready_before_accept", int'(din_ready), 1);
    din_a = a; din_b = b; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  // Returns number of edges after acceptance until dout_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!dout_valid && lat < 40);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic es);
    int lat;
    exp_t e;
    e.d = ed; e.s = es;
    exp_q.push_back(e);
    accept(a, b);
    wait_valid(lat);
    chk("latency", lat, 9);
    @(posedge clk); #1;
    chk("din_ready_after_deliver", int'(din_ready), 1);
  endtask

  initial begin
    int lat;
    exp_t e;
    reset = 1'b1; din_a = '0; din_b = '0; din_valid = 1'b0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_din_ready", int'(din_ready), 1);
    chk("reset_dout_valid", int'(dout_valid), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_dout_sat", int'(dout_sat), 0);

    run_op(8'd10,  8'd5,   8'd6,   1'b0);
    run_op(8'd12,  8'd5,   8'd8,   1'b0);
    run_op(8'd4,   8'd1,   8'd1,   1'b0);
    run_op(8'd255, 8'd255, 8'd255, 1'b1);
    run_op(8'd45,  8'd45,  8'd253, 1'b0);
    run_op(8'd0,   8'd200, 8'd0,   1'b0);
    run_op(8'd200, 8'd0,   8'd0,   1'b0);

    // Backpressure: hold result for 5 cycles while poking din_valid
    dout_ready = 1'b0;
    e.d = 8'd6; e.s = 1'b0;
    exp_q.push_back(e);
    accept(8'd10, 8'd5);
    wait_valid(lat);
    chk("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      din_a = 8'd255; din_b = 8'd255; din_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("bp_dout_hold", int'(dout), 6);
      chk("bp_valid_hold", int'(dout_valid), 1);
      chk("bp_din_ready", int'(din_ready), 0);
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", int'(dout_valid), 0);
    chk("bp_release_din_ready", int'(din_ready), 1);

    // Reset during the fourth BUSY cycle; no result may appear for it
    accept(8'd200, 8'd200);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_din_ready", int'(din_ready), 1);
    chk("abort_dout_valid", int'(dout_valid), 0);
    chk("abort_dout", int'(dout), 0);
    chk("abort_dout_sat", int'(dout_sat), 0);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dout_valid) lat++;
    end
    chk("abort_no_result", lat, 0);
    run_op(8'd3, 8'd3, 8'd1, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
